countdown_seg_timer: RTL and testbench

Parametrised mixed-radix countdown timer with integrated seven-segment drive for the bomb-defusal console. Holds the remaining time as per-digit BCD registers, so no divide/modulo chain is needed. Decrements the count at a prescaled tick rate and applies strike penalties with borrow. Signals expiry and blinks the display once time runs out. Sits between the game controller (load/start/pause/penalty) and the board HEX displays.

---
 rtl/seg_timer_pkg.sv | 50 +++++
 rtl/seg_digit_enc.sv | 31 +++
 rtl/countdown_seg_timer.sv | 160 ++++++++++++++++
 tb/tb_countdown_seg_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_timer_pkg.sv
// Shared types, segment patterns and the BCD borrow-decrement helper for
// the countdown timer.
package seg_timer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_EXPIRED} state_e;

  localparam int MAX_DIGITS = 16;
  localparam int MAXW       = 4 * MAX_DIGITS;

  // Active-low, bit 7 = DP, bits 6..0 = g..a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Subtract one unit at digit 'from' with borrow up to digit n-1.
  // MSB of the result is the borrow out of the top digit (underflow).
  function automatic logic [MAXW:0] bcd_dec(input logic [MAXW-1:0] v,
                                            input logic [MAXW-1:0] radix,
                                            input int from, input int n);
    logic [MAXW-1:0] r;
    logic            b;
    logic [3:0]      dg, rx;
    r  = v;
    b  = 1'b1;
    dg = '0;
    rx = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (b && i >= from && i < n) begin
        dg = r[4*i +: 4];
        rx = radix[4*i +: 4];
        if (dg == 4'd0) begin
          r[4*i +: 4] = rx - 4'd1;
        end else begin
          r[4*i +: 4] = dg - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

endpackage

// File: rtl/seg_digit_enc.sv
// One BCD digit to an active-low seven-segment pattern with decimal point.
module seg_digit_enc
  import seg_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    unique case (digit_i)
      4'd0: pat = SEG_0;
      4'd1: pat = SEG_1;
      4'd2: pat = SEG_2;
      4'd3: pat = SEG_3;
      4'd4: pat = SEG_4;
      4'd5: pat = SEG_5;
      4'd6: pat = SEG_6;
      4'd7: pat = SEG_7;
      4'd8: pat = SEG_8;
      4'd9: pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    seg_o = blank_i ? SEG_BLANK : {pat[7] & ~dp_i, pat[6:0]};
  end

endmodule

// File: rtl/countdown_seg_timer.sv
// Mixed-radix BCD countdown timer with prescaled tick, strike penalty,
// expiry blink and per-digit seven-segment drive.
module countdown_seg_timer
  import seg_timer_pkg::*;
#(
  parameter int                      NUM_DIGITS    = 6,
  parameter logic [4*NUM_DIGITS-1:0] RADIX         = {4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10},
  parameter int                      CLK_HZ        = 50_000_000,
  parameter int                      TICK_HZ       = 1000,
  parameter int                      BLINK_HZ      = 2,
  parameter int                      PENALTY_DIGIT = 3,
  parameter logic [NUM_DIGITS-1:0]   DP_MASK       = 6'b001000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    penalty,
  output logic [8*NUM_DIGITS-1:0] segs,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    expired,
  output logic                    expired_pulse
);

  localparam int CW   = 4 * NUM_DIGITS;
  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d, clamped;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d, pulse_q, pulse_d;
  logic            tick, do_pen, next_zero, blank;
  logic [MAXW:0]   res_pen, res_tick;
  logic [MAXW-1:0] w_pen, after_pen, w_tick, after_tick;

  assign tick   = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
  assign do_pen = penalty && !load && (state_q == ST_RUN || state_q == ST_PAUSED);

  // Penalty first, then tick on the penalised value; any underflow clamps to 0.
  assign res_pen    = bcd_dec(MAXW'(count_q), MAXW'(RADIX), PENALTY_DIGIT, NUM_DIGITS);
  assign w_pen      = res_pen[MAXW] ? '0 : res_pen[MAXW-1:0];
  assign after_pen  = do_pen ? w_pen : MAXW'(count_q);
  assign res_tick   = bcd_dec(after_pen, MAXW'(RADIX), 0, NUM_DIGITS);
  assign w_tick     = res_tick[MAXW] ? '0 : res_tick[MAXW-1:0];
  assign after_tick = tick ? w_tick : after_pen;
  assign next_zero  = (after_tick == '0);

  always_comb begin
    clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i +: 4] > RADIX[4*i +: 4] - 4'd1)
        clamped[4*i +: 4] = RADIX[4*i +: 4] - 4'd1;
      else
        clamped[4*i +: 4] = load_value[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    if (load) begin
      count_d = clamped;
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !pause) begin
            if (count_q == '0) begin
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              presc_d = '0;
            end
          end
        end
        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          count_d = after_tick[CW-1:0];
          if (next_zero) begin
            state_d = ST_EXPIRED;
            pulse_d = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          count_d = after_tick[CW-1:0];
          if (next_zero) begin
            state_d = ST_EXPIRED;
            pulse_d = 1'b1;
          end else if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: count_d = '0;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Blink phase runs only while staying in EXPIRED; it restarts at 0 on entry.
  always_comb begin
    bcnt_d  = '0;
    phase_d = 1'b0;
    if (state_q == ST_EXPIRED && !load) begin
      phase_d = phase_q;
      if (bcnt_q == BW'(HALF - 1)) begin
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  assign blank         = ~en | phase_q;
  assign count         = count_q;
  assign running       = (state_q == ST_RUN);
  assign expired       = (state_q == ST_EXPIRED);
  assign expired_pulse = pulse_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg_digit_enc u_enc (
      .digit_i (count_q[4*g +: 4]),
      .blank_i (blank),
      .dp_i    (DP_MASK[g]),
      .seg_o   (segs[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_countdown_seg_timer.sv
// Directed checks of the countdown timer with DIV=10 and a 10-cycle blink half-period.
module tb_countdown_seg_timer;

  logic        clk = 1'b0;
  logic        rst, en, load, start, pause, penalty;
  logic [23:0] load_value;
  logic [47:0] segs;
  logic [23:0] count;
  logic        running, expired, expired_pulse;
  int          checks = 0;
  int          errors = 0;

  localparam logic [47:0] SEGS_ZERO = 48'hC0C040C0C0C0;
  localparam logic [47:0] SEGS_OFF  = 48'hFFFFFFFFFFFF;

  always #5 clk = ~clk;

  countdown_seg_timer #(.CLK_HZ(20), .TICK_HZ(2), .BLINK_HZ(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .penalty(penalty), .segs(segs),
    .count(count), .running(running), .expired(expired),
    .expired_pulse(expired_pulse)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] v);
    load_value = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    penalty = 1'b0; load_value = '0;
    step(2);
    checks++;
    if (segs !== SEGS_ZERO) begin errors++; $display("FAIL reset_segs got %h exp %h", segs, SEGS_ZERO); end
    checks++;
    if ({count, running, expired, expired_pulse} !== 27'd0) begin
      errors++; $display("FAIL reset_flags got %h/%b%b%b exp 0", count, running, expired, expired_pulse);
    end
    en = 1'b0;
    #1;
    checks++;
    if (segs !== SEGS_OFF) begin errors++; $display("FAIL reset_en0 got %h exp %h", segs, SEGS_OFF); end
    en = 1'b1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_tick();
    do_load(24'h000100);
    do_start();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL tick_running got %b exp 1", running); end
    step(9);
    checks++;
    if (count !== 24'h000100) begin errors++; $display("FAIL tick_early got %h exp 000100", count); end
    step();
    checks++;
    if (count !== 24'h000099) begin errors++; $display("FAIL tick_first got %h exp 000099", count); end
    step(10);
    checks++;
    if (count !== 24'h000098) begin errors++; $display("FAIL tick_second got %h exp 000098", count); end
  endtask

  task automatic test_borrow_clamp();
    do_load(24'h010000);
    do_start();
    step(10);
    checks++;
    if (count !== 24'h005999) begin errors++; $display("FAIL borrow got %h exp 005999", count); end
    do_load(24'h07FFFF);
    checks++;
    if (count !== 24'h075999) begin errors++; $display("FAIL clamp1 got %h exp 075999", count); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL load_idle got %b exp 0", running); end
    do_load(24'h9A5B3C);
    checks++;
    if (count !== 24'h595939) begin errors++; $display("FAIL clamp2 got %h exp 595939", count); end
  endtask

  task automatic test_pause_resume();
    do_load(24'h002000);
    do_start();
    step(4);
    pause = 1'b1;
    step();
    pause = 1'b0;
    step(30);
    checks++;
    if (count !== 24'h002000 || running !== 1'b0) begin
      errors++; $display("FAIL paused got %h run %b exp 002000 run 0", count, running);
    end
    do_start();
    step(4);
    checks++;
    if (count !== 24'h002000) begin errors++; $display("FAIL resume_early got %h exp 002000", count); end
    step();
    checks++;
    if (count !== 24'h001999) begin errors++; $display("FAIL resume_tick got %h exp 001999", count); end
  endtask

  task automatic test_penalty();
    do_load(24'h003000);
    penalty = 1'b1;
    step();
    penalty = 1'b0;
    checks++;
    if (count !== 24'h003000) begin errors++; $display("FAIL pen_idle got %h exp 003000", count); end
    do_load(24'h003456);
    do_start();
    penalty = 1'b1;
    step();
    penalty = 1'b0;
    checks++;
    if (count !== 24'h002456 || running !== 1'b1) begin
      errors++; $display("FAIL pen_run got %h run %b exp 002456 run 1", count, running);
    end
  endtask

  task automatic test_expire_blink();
    do_load(24'h000500);
    do_start();
    penalty = 1'b1;
    step();
    penalty = 1'b0;
    checks++;
    if ({count, expired, expired_pulse, running} !== {24'h0, 3'b110}) begin
      errors++; $display("FAIL pen_expire got %h e%b p%b r%b exp 0 e1 p1 r0", count, expired, expired_pulse, running);
    end
    step();
    checks++;
    if (expired_pulse !== 1'b0) begin errors++; $display("FAIL pulse_len got %b exp 0", expired_pulse); end
    step(8);
    checks++;
    if (segs !== SEGS_ZERO) begin errors++; $display("FAIL blink_on got %h exp %h", segs, SEGS_ZERO); end
    step();
    checks++;
    if (segs !== SEGS_OFF) begin errors++; $display("FAIL blink_off got %h exp %h", segs, SEGS_OFF); end
    step(10);
    checks++;
    if (segs !== SEGS_ZERO) begin errors++; $display("FAIL blink_on2 got %h exp %h", segs, SEGS_ZERO); end
    do_start();
    checks++;
    if (expired !== 1'b1) begin errors++; $display("FAIL start_in_exp got %b exp 1", expired); end
    do_load(24'h000300);
    checks++;
    if ({count, expired} !== {24'h000300, 1'b0}) begin
      errors++; $display("FAIL exp_load got %h e%b exp 000300 e0", count, expired);
    end
    checks++;
    if (segs !== 48'hC0C040B0C0C0) begin errors++; $display("FAIL exp_load_segs got %h exp C0C040B0C0C0", segs); end
  endtask

  task automatic test_back_to_back();
    do_load(24'h001000);
    do_start();
    step(9);
    penalty = 1'b1;
    step();
    penalty = 1'b0;
    checks++;
    if ({count, expired, expired_pulse} !== {24'h0, 2'b11}) begin
      errors++; $display("FAIL pen_tick got %h e%b p%b exp 0 e1 p1", count, expired, expired_pulse);
    end
    do_load(24'h000000);
    do_start();
    checks++;
    if ({expired, expired_pulse, running} !== 3'b110) begin
      errors++; $display("FAIL start_zero got e%b p%b r%b exp e1 p1 r0", expired, expired_pulse, running);
    end
  endtask

  task automatic test_en_async_reset();
    do_load(24'h000020);
    do_start();
    en = 1'b0;
    step(10);
    checks++;
    if (segs !== SEGS_OFF || count !== 24'h000019) begin
      errors++; $display("FAIL en_blank got %h cnt %h exp all FF cnt 000019", segs, count);
    end
    en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count, running} !== 25'd0 || segs !== SEGS_ZERO) begin
      errors++; $display("FAIL async_rst got %h r%b segs %h exp 0 r0 %h", count, running, segs, SEGS_ZERO);
    end
    step();
    rst = 1'b0;
    do_load(24'h000042);
    checks++;
    if (count !== 24'h000042) begin errors++; $display("FAIL post_rst got %h exp 000042", count); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_borrow_clamp();
    test_pause_resume();
    test_penalty();
    test_expire_blink();
    test_back_to_back();
    test_en_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
